disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Shares the single 4-digit seven-segment display between three requesters: the input prompt, the PC viewer and the data-value viewer.
- Arbitrates by fixed priority and latches the winning value.
- Converts that value to BCD with a sequential shift-add-3 engine, then time-multiplexes the digits.
- Sits between the control FSM and the board segment/anode pins and drives the busy LED bank.

Parameters:
REFRESH_DIV, 1024, clk cycles per digit slot (legal range 2..65535)
BUSY_PATTERN, 8'hFF, s_led value while busy is high

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
inp_req  input  1  input-prompt requester; level, held while display wanted
pc_req  input  1  PC-viewer requester; level
pc_data  input  8  PC value, binary
val_req  input  1  value-viewer requester; level
val_data  input  8  data value, binary
busy  input  1  CPU busy flag
grant  output  3  one-hot owner: [2]=inp, [1]=pc, [0]=val; 0 = none
conv_busy  output  1  high while BCD conversion is running
seg_n  output  7  segments gfedcba, active-low
an_n  output  4  digit enables, active-low; an_n[3]=leftmost
s_led  output  8  busy LED bank

Behaviour:
- Clock is clk. Reset is asynchronous and active-low (rst_n).
- Reset values, applied asynchronously (including mid-conversion or mid-scan): grant=0, conv_busy=0, seg_n=7'h7F, an_n=4'hF, s_led=0, BCD register=0, refresh counter=0, slot=0, FSM=IDLE.
- s_led: registered; equals BUSY_PATTERN when busy=1, else 0. One-cycle latency; independent of the FSM.
- Arbitration:
  - Priority is inp > pc > val.
  - Evaluated only in IDLE and SHOW.
  - A higher-priority request pre-empts the current owner at the next clk edge.
  - When the owner's req drops, re-arbitrate at the same edge. With no req active, go to IDLE.
  - grant is registered and changes only on these edges.
- FSM states:
  - IDLE: an_n=4'hF. On any req, set grant and go to LOAD.
  - LOAD: capture the owner's data into an 8-bit shift register (0 for inp) and clear the scratch BCD. Next state is CONV. conv_busy=1.
  - CONV: exactly 8 cycles of double-dabble. Each cycle, add 3 to every BCD nibble >=5, then shift left 1 bit. After the 8th cycle, copy the scratch BCD (hundreds 0..2, tens, units) to the display BCD register, clear conv_busy and go to SHOW. LOAD-to-visible latency is 9 clk.
  - SHOW: if the owner's data differs from the captured value, or grant changes, go to LOAD. Otherwise hold.
- Conversion is not restarted mid-CONV by data changes; the change is detected in SHOW afterwards.
- Pre-emption or owner drop during CONV aborts: set the new grant and go to LOAD (or to IDLE if no req).
- The display BCD register changes only at the end of CONV, so no partial digits are ever shown.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, slot = slot+1 mod 4.
  - Scan runs in every state except IDLE.
  - Slot s drives an_n low on bit 3-s only; one hot-low at a time. seg_n and an_n are registered.
- Glyphs (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, P=0001100, C=1000110, I=1111001, n=1101010, blank=1111111.
- Slot content by owner:
  - inp: blank, I, n, P.
  - pc: P, C, tens, units. The hundreds digit is dropped, so the value is shown mod 100.
  - val: blank, hundreds, tens, units.
- Illegal grant or nibble values (>9) show blank.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined, in val mode: hundreds shows blank when 0; tens shows blank when hundreds and tens are both 0; units is always shown. pc mode is unaffected.
- When undefined, all val digits are shown, including leading zeros.

Test Plan:
- Reset: assert rst_n=0 mid-CONV -> same cycle grant=0, an_n=4'hF, seg_n=7'h7F, s_led=0, conv_busy=0.
- REFRESH_DIV=4, val_req=1, val_data=8'd157 -> conv_busy high for 9 clk. Then slots give blank, 1, 5, 7 (an_n 0111, 1011, 1101, 1110), each slot held 4 clk.
- val_req=1 (data 42), then pc_req=1 with pc_data=8'd203 -> grant 001->010 on the next edge. Display P, C, 0, 3. Dropping pc_req returns to val showing 4, 2 (with leading-zero-blank: blank, blank, 4, 2).
- inp_req=1 asserted during val CONV -> conversion aborted, grant=100, glyphs blank, I, n, P.
- val_data changes 255->0 while in SHOW -> reload. The old digits 2, 5, 5 stay on until 9 clk later, then 0, 0, 0 (or blank, blank, 0 with the macro).
- busy toggled 0->1->0 in any state -> s_led goes 8'hFF then 8'h00 with 1 clk latency each.

Source files
------------

// File: rtl/disp_arbiter_if.sv
// Requester bus for disp_arbiter: level requests and binary data in, one-hot grant out.
interface disp_arbiter_if;
    logic       inp_req;
    logic       pc_req;
    logic [7:0] pc_data;
    logic       val_req;
    logic [7:0] val_data;
    logic [2:0] grant;

    // Requester side: drives requests and data, observes the grant.
    modport master (
        output inp_req,
        output pc_req,
        output pc_data,
        output val_req,
        output val_data,
        input  grant
    );

    // Arbiter side.
    modport slave (
        input  inp_req,
        input  pc_req,
        input  pc_data,
        input  val_req,
        input  val_data,
        output grant
    );
endinterface

// File: rtl/disp_arbiter.sv
// disp_arbiter: fixed-priority (inp > pc > val) owner of the 4-digit display.
// Latches the owner's value, converts it to BCD with an 8-step shift-add-3
// engine and scans the digits. Optional macro LEADING_ZERO_BLANK_EN blanks
// leading zeros of the value viewer.
module disp_arbiter #(
    parameter int unsigned REFRESH_DIV  = 1024,
    parameter logic [7:0]  BUSY_PATTERN = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_arbiter_if.slave    req_if,
    input  logic             busy,
    output logic             conv_busy,
    output logic [6:0]       seg_n,
    output logic [3:0]       an_n,
    output logic [7:0]       s_led
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SCR_W = 20;

    // Glyph codes: 0..9 are digits, the rest are letters or blank.
    localparam logic [3:0] C_P     = 4'd10;
    localparam logic [3:0] C_C     = 4'd11;
    localparam logic [3:0] C_I     = 4'd12;
    localparam logic [3:0] C_N     = 4'd13;
    localparam logic [3:0] C_BLANK = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_SHOW
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_grant;
    logic [2:0]         w_grant_nxt;
    logic [2:0]         w_arb;
    logic [7:0]         w_owner_data;
    logic [7:0]         r_cap;
    logic [SCR_W-1:0]   r_scr;
    logic [SCR_W-1:0]   w_scr_adj;
    logic [SCR_W-1:0]   w_scr_shift;
    logic [2:0]         r_step;
    logic [11:0]        r_disp;
    logic               w_load;
    logic               w_step;
    logic               w_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_slot;
    logic [3:0]         w_code;
    logic               r_conv_busy;
    logic [6:0]         r_seg_n;
    logic [3:0]         r_an_n;
    logic [7:0]         r_s_led;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    function automatic logic [3:0] dig(input logic [3:0] n);
        return (n > 4'd9) ? C_BLANK : n;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            C_P:     return 7'b0001100;
            C_C:     return 7'b1000110;
            C_I:     return 7'b1111001;
            C_N:     return 7'b1101010;
            default: return 7'b1111111;
        endcase
    endfunction

    // Fixed-priority request encoder and the current owner's data.
    always_comb begin
        w_arb        = 3'b000;
        w_owner_data = 8'h00;
        if (req_if.inp_req)      w_arb = 3'b100;
        else if (req_if.pc_req)  w_arb = 3'b010;
        else if (req_if.val_req) w_arb = 3'b001;
        case (r_grant)
            3'b010:  w_owner_data = req_if.pc_data;
            3'b001:  w_owner_data = req_if.val_data;
            default: w_owner_data = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, next grant and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb != 3'b000) begin
                    w_grant_nxt = w_arb;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_CONV;
            end
            ST_CONV: begin
                // Pre-emption or owner drop aborts; data changes wait for SHOW.
                if (w_arb != r_grant) begin
                    w_grant_nxt = w_arb;
                    w_state_nxt = (w_arb == 3'b000) ? ST_IDLE : ST_LOAD;
                end else begin
                    w_step = 1'b1;
                    if (r_step == 3'd7) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                if (w_arb != r_grant) begin
                    w_grant_nxt = w_arb;
                    w_state_nxt = (w_arb == 3'b000) ? ST_IDLE : ST_LOAD;
                end else if (w_owner_data != r_cap) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant and conversion-busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= 3'b000;
            r_conv_busy <= 1'b0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_conv_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CONV);
        end
    end

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        w_scr_adj        = r_scr;
        w_scr_adj[19:16] = add3(r_scr[19:16]);
        w_scr_adj[15:12] = add3(r_scr[15:12]);
        w_scr_adj[11:8]  = add3(r_scr[11:8]);
        w_scr_shift      = {w_scr_adj[SCR_W-2:0], 1'b0};
    end

    // Capture, conversion steps and display BCD update at the end of conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap  <= 8'h00;
            r_scr  <= '0;
            r_step <= 3'd0;
            r_disp <= 12'h000;
        end else if (w_load) begin
            r_cap  <= w_owner_data;
            r_scr  <= {12'h000, w_owner_data};
            r_step <= 3'd0;
        end else if (w_step) begin
            r_scr  <= w_scr_shift;
            r_step <= 3'(r_step + 3'd1);
            if (w_done) r_disp <= w_scr_shift[19:8];
        end
    end

    // Refresh counter and digit slot; frozen while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= 2'd0;
        end else if (r_state != ST_IDLE) begin
            if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_cnt  <= '0;
                r_slot <= 2'(r_slot + 2'd1);
            end else begin
                r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
            end
        end
    end

    // Glyph code for the current slot based on the owner.
    always_comb begin
        w_code = C_BLANK;
        case (r_grant)
            3'b100: begin
                case (r_slot)
                    2'd0:    w_code = C_BLANK;
                    2'd1:    w_code = C_I;
                    2'd2:    w_code = C_N;
                    default: w_code = C_P;
                endcase
            end
            3'b010: begin
                case (r_slot)
                    2'd0:    w_code = C_P;
                    2'd1:    w_code = C_C;
                    2'd2:    w_code = dig(r_disp[7:4]);
                    default: w_code = dig(r_disp[3:0]);
                endcase
            end
            3'b001: begin
                case (r_slot)
                    2'd0:    w_code = C_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
                    2'd1:    w_code = (r_disp[11:8] == 4'd0) ? C_BLANK : dig(r_disp[11:8]);
                    2'd2:    w_code = (r_disp[11:4] == 8'd0) ? C_BLANK : dig(r_disp[7:4]);
`else
                    2'd1:    w_code = dig(r_disp[11:8]);
                    2'd2:    w_code = dig(r_disp[7:4]);
`endif
                    default: w_code = dig(r_disp[3:0]);
                endcase
            end
            default: w_code = C_BLANK;
        endcase
    end

    // Registered segment/anode drive; dark while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n <= 7'h7F;
            r_an_n  <= 4'hF;
        end else if (w_state_nxt == ST_IDLE) begin
            r_seg_n <= 7'h7F;
            r_an_n  <= 4'hF;
        end else begin
            r_seg_n <= glyph(w_code);
            r_an_n  <= 4'(~(4'b1000 >> r_slot));
        end
    end

    // Busy LED bank, independent of the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s_led <= 8'h00;
        else        r_s_led <= busy ? BUSY_PATTERN : 8'h00;
    end

    assign req_if.grant = r_grant;
    assign conv_busy    = r_conv_busy;
    assign seg_n        = r_seg_n;
    assign an_n         = r_an_n;
    assign s_led        = r_s_led;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter with a short refresh period.
module tb_disp_arbiter;

    localparam int unsigned REFDIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] G_0  = 7'b1000000;
    localparam logic [6:0] G_1  = 7'b1111001;
    localparam logic [6:0] G_2  = 7'b0100100;
    localparam logic [6:0] G_3  = 7'b0110000;
    localparam logic [6:0] G_4  = 7'b0011001;
    localparam logic [6:0] G_5  = 7'b0010010;
    localparam logic [6:0] G_7  = 7'b1111000;
    localparam logic [6:0] G_P  = 7'b0001100;
    localparam logic [6:0] G_C  = 7'b1000110;
    localparam logic [6:0] G_I  = 7'b1111001;
    localparam logic [6:0] G_N  = 7'b1101010;
    localparam logic [6:0] G_BL = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic       conv_busy;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [7:0] s_led;

    disp_arbiter_if u_if ();

    disp_arbiter #(
        .REFRESH_DIV  (REFDIV),
        .BUSY_PATTERN (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (u_if.slave),
        .busy      (busy),
        .conv_busy (conv_busy),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .s_led     (s_led)
    );

    int total = 0;
    int bad   = 0;

    logic [10:0] sb_q[$];
    logic [3:0]  prev_an = 4'hF;
    int          run_len = 0;
    bit          chk_run = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: every anode change pops one expected {an_n, seg_n} and checks slot hold length.
    always @(negedge clk) begin
        logic [10:0] e;
        if (an_n !== prev_an) begin
            if (chk_run) chk("slot_hold", 32'(run_len), 32'(REFDIV));
            chk_run = 1'b0;
            run_len = 1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("slot_an", 32'(an_n), 32'(e[10:7]));
                chk("slot_seg", 32'(seg_n), 32'(e[6:0]));
                chk_run = (sb_q.size() > 0);
            end
        end else begin
            run_len++;
        end
        prev_an = an_n;
    end

    // Wait for the conversion pulse and check how many cycles it lasted.
    task automatic conv_len(input string nm, input int exp_len);
        int guard = 0;
        int n = 0;
        while (!conv_busy && guard < 20) begin tick(); guard++; end
        while (conv_busy && n < 40) begin n++; tick(); end
        chk(nm, 32'(n), 32'(exp_len));
    endtask

    // Align to the start of slot 3, then queue the four expected slots.
    task automatic show_check(input string nm, input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3);
        int guard = 0;
        logic [3:0] last;
        last = an_n;
        while (!(an_n == 4'b1110 && last != 4'b1110) && guard < 60) begin
            last = an_n;
            tick();
            guard++;
        end
        if (guard >= 60) timeout({nm, "_sync"});
        tick();
        sb_q.push_back({4'b0111, g0});
        sb_q.push_back({4'b1011, g1});
        sb_q.push_back({4'b1101, g2});
        sb_q.push_back({4'b1110, g3});
        guard = 0;
        while (sb_q.size() > 0 && guard < 40) begin tick(); guard++; end
        if (sb_q.size() > 0) begin
            timeout({nm, "_drain"});
            sb_q.delete();
        end
    endtask

    function automatic logic [6:0] old_glyph(input logic [3:0] an, input logic [6:0] g0,
                                            input logic [6:0] g1, input logic [6:0] g2,
                                            input logic [6:0] g3);
        case (an)
            4'b0111: return g0;
            4'b1011: return g1;
            4'b1101: return g2;
            4'b1110: return g3;
            default: return 7'h00;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n          = 1'b0;
        busy           = 1'b0;
        u_if.inp_req   = 1'b0;
        u_if.pc_req    = 1'b0;
        u_if.pc_data   = 8'd0;
        u_if.val_req   = 1'b0;
        u_if.val_data  = 8'd0;
        repeat (3) tick();
        chk("rst_grant", 32'(u_if.grant), 32'h0);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_sled", 32'(s_led), 32'h0);
        chk("rst_conv", 32'(conv_busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // Value viewer 157.
        u_if.val_req  = 1'b1;
        u_if.val_data = 8'd157;
        tick();
        chk("val_grant", 32'(u_if.grant), 32'b001);
        conv_len("val157_conv", 9);
        show_check("val157", G_BL, G_1, G_5, G_7);

        // Reload on data change to 42.
        u_if.val_data = 8'd42;
        conv_len("val42_conv", 9);
        show_check("val42", G_BL, LZB ? G_BL : G_0, G_4, G_2);

        // PC viewer pre-empts.
        u_if.pc_req  = 1'b1;
        u_if.pc_data = 8'd203;
        tick();
        chk("pc_grant", 32'(u_if.grant), 32'b010);
        conv_len("pc203_conv", 9);
        show_check("pc203", G_P, G_C, G_0, G_3);

        // PC drops, value viewer returns.
        u_if.pc_req = 1'b0;
        tick();
        chk("pcdrop_grant", 32'(u_if.grant), 32'b001);
        conv_len("val42b_conv", 9);
        show_check("val42b", G_BL, LZB ? G_BL : G_0, G_4, G_2);

        // Input prompt aborts a running value conversion.
        u_if.val_data = 8'd99;
        repeat (3) tick();
        chk("abort_pre_conv", 32'(conv_busy), 32'h1);
        u_if.inp_req = 1'b1;
        tick();
        chk("inp_grant", 32'(u_if.grant), 32'b100);
        conv_len("inp_conv", 9);
        show_check("inp", G_BL, G_I, G_N, G_P);

        // Back to value viewer with 255.
        u_if.inp_req  = 1'b0;
        u_if.val_data = 8'd255;
        tick();
        chk("inpdrop_grant", 32'(u_if.grant), 32'b001);
        conv_len("val255_conv", 9);
        show_check("val255", G_BL, G_2, G_5, G_5);

        // 255 -> 0: old digits stay up for the whole conversion.
        u_if.val_data = 8'd0;
        guard = 0;
        while (!conv_busy && guard < 20) begin tick(); guard++; end
        guard = 0;
        while (conv_busy && guard < 20) begin
            chk("hold_old", 32'(seg_n), 32'(old_glyph(an_n, G_BL, G_2, G_5, G_5)));
            tick();
            guard++;
        end
        chk("hold_old_len", 32'(guard), 32'd9);
        show_check("val0", G_BL, LZB ? G_BL : G_0, LZB ? G_BL : G_0, G_0);

        // Busy LEDs, one cycle latency each way.
        busy = 1'b1;
        #1;
        chk("sled_not_yet", 32'(s_led), 32'h00);
        tick();
        chk("sled_on", 32'(s_led), 32'hFF);
        busy = 1'b0;
        tick();
        chk("sled_off", 32'(s_led), 32'h00);

        // No requests: back to idle, display dark.
        u_if.val_req = 1'b0;
        tick();
        chk("idle_grant", 32'(u_if.grant), 32'h0);
        chk("idle_an", 32'(an_n), 32'hF);
        chk("idle_conv", 32'(conv_busy), 32'h0);

        // Asynchronous reset in the middle of a conversion.
        busy          = 1'b1;
        u_if.val_req  = 1'b1;
        u_if.val_data = 8'd157;
        repeat (4) tick();
        chk("mid_conv", 32'(conv_busy), 32'h1);
        chk("mid_sled", 32'(s_led), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(u_if.grant), 32'h0);
        chk("arst_an", 32'(an_n), 32'hF);
        chk("arst_seg", 32'(seg_n), 32'h7F);
        chk("arst_sled", 32'(s_led), 32'h0);
        chk("arst_conv", 32'(conv_busy), 32'h0);
        busy          = 1'b0;
        u_if.val_req  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", 32'(u_if.grant), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
